// File: rtl/alu4_seq.sv
// Command-side sequencer driving a 4-bit ALU one nibble per cycle, LSB first.
// Optional feature: define ALU4_SEQ_STATS_EN to add the o_op_count handshake counter.
module alu4_seq #(
    parameter int unsigned NIBBLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [4*NIBBLES-1:0]   i_cmd_a,
    input  logic [4*NIBBLES-1:0]   i_cmd_b,
    input  logic [2:0]             i_cmd_op,
    input  logic                   i_cmd_cin,
    output logic [3:0]             o_alu_a,
    output logic [3:0]             o_alu_b,
    output logic [2:0]             o_alu_c,
    output logic                   o_alu_cin,
    input  logic [3:0]             i_alu_result,
    input  logic                   i_alu_zero,
    input  logic                   i_alu_overflow,
    input  logic                   i_alu_carry,
    input  logic                   i_alu_size,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [4*NIBBLES-1:0]   o_rsp_result,
    output logic [3:0]             o_rsp_flags
`ifdef ALU4_SEQ_STATS_EN
    ,
    output logic [15:0]            o_op_count
`endif
);

    localparam int unsigned WIDTH = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [2:0]         r_alu_c;
    logic               r_alu_cin;
    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_size_and;
    logic               r_zero;
    logic               r_ovf;
    logic               r_carry;
    logic               r_size;
    logic               w_accept;
    logic               w_last;
    logic               w_rsp_hs;
    logic               w_arith_cmd;
    logic               w_arith_run;
    logic [WIDTH-1:0]   w_result_nxt;
    logic               w_unused;

    // Arithmetic/compare ops (000, 001, 110, 111) are exactly those with op[2] == op[1].
    assign w_arith_cmd = i_cmd_op[2] ~^ i_cmd_op[1];
    assign w_arith_run = r_op[2] ~^ r_op[1];
    assign w_accept    = i_cmd_valid && r_cmd_ready && (r_state == S_IDLE);
    assign w_last      = (r_idx == IDX_W'(NIBBLES - 1));
    assign w_rsp_hs    = (r_state == S_DONE) && i_rsp_ready;
    assign w_unused    = i_alu_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)   w_state_nxt = S_DONE;
            S_DONE:  if (w_rsp_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_result_nxt = r_result;
        w_result_nxt[{r_idx, 2'b00} +: 4] = i_alu_result;
    end

    // Operands shift down so the ALU nibble is always bit [3:0]; they drain to 0 by DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_alu_c     <= '0;
            r_alu_cin   <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_result    <= '0;
            r_size_and  <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_carry     <= 1'b0;
            r_size      <= 1'b0;
        end else begin
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_a        <= i_cmd_a;
                r_b        <= i_cmd_b;
                r_op       <= i_cmd_op;
                r_alu_c    <= i_cmd_op;
                r_alu_cin  <= i_cmd_cin & w_arith_cmd;
                r_idx      <= '0;
                r_result   <= '0;
                r_size_and <= 1'b1;
            end else if (r_state == S_RUN) begin
                r_a        <= r_a >> 4;
                r_b        <= r_b >> 4;
                r_result   <= w_result_nxt;
                r_size_and <= r_size_and & i_alu_size;
                if (w_last) begin
                    r_idx     <= '0;
                    r_alu_c   <= '0;
                    r_alu_cin <= 1'b0;
                    r_zero    <= ~|w_result_nxt;
                    r_ovf     <= w_arith_run & i_alu_overflow;
                    r_carry   <= w_arith_run & i_alu_carry;
                    if (r_op == 3'b110) begin
                        r_size <= i_alu_size;
                    end else if (r_op == 3'b111) begin
                        r_size <= r_size_and & i_alu_size;
                    end else begin
                        r_size <= 1'b0;
                    end
                end else begin
                    r_idx     <= r_idx + IDX_W'(1);
                    r_alu_cin <= w_arith_run & i_alu_carry;
                end
            end
        end
    end

`ifdef ALU4_SEQ_STATS_EN
    logic [15:0] r_op_count;

    // Saturating count of completed response handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_rsp_hs && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign o_op_count = r_op_count;
`endif

    assign o_cmd_ready  = r_cmd_ready;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_result = r_result;
    assign o_rsp_flags  = {r_zero, r_ovf, r_carry, r_size};
    assign o_alu_a      = r_a[3:0];
    assign o_alu_b      = r_b[3:0];
    assign o_alu_c      = r_alu_c;
    assign o_alu_cin    = r_alu_cin;

endmodule
